// File: rtl/network_bf_out.sv
// rtl/network_bf_out.sv - butterfly write-back network: delays descriptors to meet butterfly outputs and routes them to eight banks
//
// Purpose:
//   A write-back descriptor is issued at cycle t. It carries a valid flag, a
//   per-bank write mask, a per-bank source select and a per-bank write
//   address. The descriptor travels through a bf_latency-deep shift pipeline
//   so that it lines up with the butterfly outputs u0..v3 at cycle
//   t+bf_latency. Each bank then picks its source and gets its write strobe.
//
// Ports:
//   clk                  clock, all state on the rising edge
//   rst                  asynchronous active-low reset
//   in_valid             descriptor issued this cycle
//   sel_b_0..sel_b_7     per-bank source (0=u0,1=v0,2=u1,3=v1,4=u2,5=v2,6=u3,7=v3)
//   wa_in_0..wa_in_7     per-bank write address
//   wr_mask              per-bank write enable
//   u0,v0..u3,v3         butterfly outputs
//   d0..d7               per-bank write data (0 when the strobe is low)
//   wa0..wa7             per-bank write address (0 when the strobe is low)
//   wen                  per-bank write strobe
//   busy                 any valid descriptor still in flight
//
// Configuration:
//   NETWORK_BF_OUT_OUTREG_EN  register d/wa/wen after the mux (latency bf_latency+1)

module network_bf_out #(
    parameter int data_width = 14,
    parameter int addr_width = 6,
    parameter int bf_latency = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2:0]            sel_b_0,
    input  logic [2:0]            sel_b_1,
    input  logic [2:0]            sel_b_2,
    input  logic [2:0]            sel_b_3,
    input  logic [2:0]            sel_b_4,
    input  logic [2:0]            sel_b_5,
    input  logic [2:0]            sel_b_6,
    input  logic [2:0]            sel_b_7,
    input  logic [addr_width-1:0] wa_in_0,
    input  logic [addr_width-1:0] wa_in_1,
    input  logic [addr_width-1:0] wa_in_2,
    input  logic [addr_width-1:0] wa_in_3,
    input  logic [addr_width-1:0] wa_in_4,
    input  logic [addr_width-1:0] wa_in_5,
    input  logic [addr_width-1:0] wa_in_6,
    input  logic [addr_width-1:0] wa_in_7,
    input  logic [7:0]            wr_mask,
    input  logic [data_width-1:0] u0,
    input  logic [data_width-1:0] v0,
    input  logic [data_width-1:0] u1,
    input  logic [data_width-1:0] v1,
    input  logic [data_width-1:0] u2,
    input  logic [data_width-1:0] v2,
    input  logic [data_width-1:0] u3,
    input  logic [data_width-1:0] v3,
    output logic [data_width-1:0] d0,
    output logic [data_width-1:0] d1,
    output logic [data_width-1:0] d2,
    output logic [data_width-1:0] d3,
    output logic [data_width-1:0] d4,
    output logic [data_width-1:0] d5,
    output logic [data_width-1:0] d6,
    output logic [data_width-1:0] d7,
    output logic [addr_width-1:0] wa0,
    output logic [addr_width-1:0] wa1,
    output logic [addr_width-1:0] wa2,
    output logic [addr_width-1:0] wa3,
    output logic [addr_width-1:0] wa4,
    output logic [addr_width-1:0] wa5,
    output logic [addr_width-1:0] wa6,
    output logic [addr_width-1:0] wa7,
    output logic [7:0]            wen,
    output logic                  busy
);

    localparam int SEL_W = 8 * 3;
    localparam int WA_W  = 8 * addr_width;
    localparam int LAST  = bf_latency - 1;

    // Descriptor fields packed per stage so the shift is a simple copy.
    logic             vld_d;
    logic [7:0]       msk_d;
    logic [SEL_W-1:0] sel_d;
    logic [WA_W-1:0]  wa_d;

    logic [bf_latency-1:0] vld_q;
    logic [7:0]            msk_q [bf_latency];
    logic [SEL_W-1:0]      sel_q [bf_latency];
    logic [WA_W-1:0]       wa_q  [bf_latency];

    assign vld_d = in_valid;
    assign msk_d = wr_mask;
    assign sel_d = {sel_b_7, sel_b_6, sel_b_5, sel_b_4, sel_b_3, sel_b_2, sel_b_1, sel_b_0};
    assign wa_d  = {wa_in_7, wa_in_6, wa_in_5, wa_in_4, wa_in_3, wa_in_2, wa_in_1, wa_in_0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int k = 0; k < bf_latency; k++) begin
                msk_q[k] <= '0;
                sel_q[k] <= '0;
                wa_q[k]  <= '0;
            end
        end else begin
            vld_q[0] <= vld_d;
            msk_q[0] <= msk_d;
            sel_q[0] <= sel_d;
            wa_q[0]  <= wa_d;
            for (int k = 1; k < bf_latency; k++) begin
                vld_q[k] <= vld_q[k-1];
                msk_q[k] <= msk_q[k-1];
                sel_q[k] <= sel_q[k-1];
                wa_q[k]  <= wa_q[k-1];
            end
        end
    end

    // Source table in select-code order.
    logic [data_width-1:0] src [8];
    assign src[0] = u0;
    assign src[1] = v0;
    assign src[2] = u1;
    assign src[3] = v1;
    assign src[4] = u2;
    assign src[5] = v2;
    assign src[6] = u3;
    assign src[7] = v3;

    logic [7:0]            mux_wen;
    logic [data_width-1:0] mux_d  [8];
    logic [addr_width-1:0] mux_wa [8];

    // Each bank has exactly one source, so a plain index replaces any priority
    // logic; disabled banks are forced to zero on both data and address.
    always_comb begin
        mux_wen = '0;
        for (int i = 0; i < 8; i++) begin
            mux_wen[i] = vld_q[LAST] & msk_q[LAST][i];
            mux_d[i]   = mux_wen[i] ? src[sel_q[LAST][i*3 +: 3]] : '0;
            mux_wa[i]  = mux_wen[i] ? wa_q[LAST][i*addr_width +: addr_width] : '0;
        end
    end

    logic [7:0]            out_wen;
    logic [data_width-1:0] out_d  [8];
    logic [addr_width-1:0] out_wa [8];

`ifdef NETWORK_BF_OUT_OUTREG_EN
    logic                  ovld_q;
    logic [7:0]            owen_q;
    logic [data_width-1:0] od_q  [8];
    logic [addr_width-1:0] owa_q [8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovld_q <= 1'b0;
            owen_q <= '0;
            for (int i = 0; i < 8; i++) begin
                od_q[i]  <= '0;
                owa_q[i] <= '0;
            end
        end else begin
            ovld_q <= vld_q[LAST];
            owen_q <= mux_wen;
            for (int i = 0; i < 8; i++) begin
                od_q[i]  <= mux_d[i];
                owa_q[i] <= mux_wa[i];
            end
        end
    end

    always_comb begin
        out_wen = owen_q;
        for (int i = 0; i < 8; i++) begin
            out_d[i]  = od_q[i];
            out_wa[i] = owa_q[i];
        end
    end

    assign busy = (|vld_q) | ovld_q;
`else
    always_comb begin
        out_wen = mux_wen;
        for (int i = 0; i < 8; i++) begin
            out_d[i]  = mux_d[i];
            out_wa[i] = mux_wa[i];
        end
    end

    assign busy = |vld_q;
`endif

    assign wen = out_wen;
    assign d0  = out_d[0];
    assign d1  = out_d[1];
    assign d2  = out_d[2];
    assign d3  = out_d[3];
    assign d4  = out_d[4];
    assign d5  = out_d[5];
    assign d6  = out_d[6];
    assign d7  = out_d[7];
    assign wa0 = out_wa[0];
    assign wa1 = out_wa[1];
    assign wa2 = out_wa[2];
    assign wa3 = out_wa[3];
    assign wa4 = out_wa[4];
    assign wa5 = out_wa[5];
    assign wa6 = out_wa[6];
    assign wa7 = out_wa[7];

endmodule

// File: tb/tb_network_bf_out.sv
// tb/tb_network_bf_out.sv - self-checking bench for network_bf_out at bf_latency 4 and 1

module tb_network_bf_out;

`ifdef NETWORK_BF_OUT_OUTREG_EN
    localparam int OUT = 1;
`else
    localparam int OUT = 0;
`endif
    localparam int LAT_A = 4 + OUT;
    localparam int LAT_B = 1 + OUT;
    localparam int N     = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  sel_b [8];
    logic [5:0]  wa_in [8];
    logic [7:0]  wr_mask;
    logic [13:0] uv [8];

    logic [13:0] d_a [8];
    logic [5:0]  wa_a [8];
    logic [7:0]  wen_a;
    logic        busy_a;
    logic [13:0] d_b [8];
    logic [5:0]  wa_b [8];
    logic [7:0]  wen_b;
    logic        busy_b;

    always #5 clk = ~clk;

    network_bf_out #(.data_width(14), .addr_width(6), .bf_latency(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .sel_b_0(sel_b[0]), .sel_b_1(sel_b[1]), .sel_b_2(sel_b[2]), .sel_b_3(sel_b[3]),
        .sel_b_4(sel_b[4]), .sel_b_5(sel_b[5]), .sel_b_6(sel_b[6]), .sel_b_7(sel_b[7]),
        .wa_in_0(wa_in[0]), .wa_in_1(wa_in[1]), .wa_in_2(wa_in[2]), .wa_in_3(wa_in[3]),
        .wa_in_4(wa_in[4]), .wa_in_5(wa_in[5]), .wa_in_6(wa_in[6]), .wa_in_7(wa_in[7]),
        .wr_mask(wr_mask),
        .u0(uv[0]), .v0(uv[1]), .u1(uv[2]), .v1(uv[3]),
        .u2(uv[4]), .v2(uv[5]), .u3(uv[6]), .v3(uv[7]),
        .d0(d_a[0]), .d1(d_a[1]), .d2(d_a[2]), .d3(d_a[3]),
        .d4(d_a[4]), .d5(d_a[5]), .d6(d_a[6]), .d7(d_a[7]),
        .wa0(wa_a[0]), .wa1(wa_a[1]), .wa2(wa_a[2]), .wa3(wa_a[3]),
        .wa4(wa_a[4]), .wa5(wa_a[5]), .wa6(wa_a[6]), .wa7(wa_a[7]),
        .wen(wen_a), .busy(busy_a)
    );

    network_bf_out #(.data_width(14), .addr_width(6), .bf_latency(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .sel_b_0(sel_b[0]), .sel_b_1(sel_b[1]), .sel_b_2(sel_b[2]), .sel_b_3(sel_b[3]),
        .sel_b_4(sel_b[4]), .sel_b_5(sel_b[5]), .sel_b_6(sel_b[6]), .sel_b_7(sel_b[7]),
        .wa_in_0(wa_in[0]), .wa_in_1(wa_in[1]), .wa_in_2(wa_in[2]), .wa_in_3(wa_in[3]),
        .wa_in_4(wa_in[4]), .wa_in_5(wa_in[5]), .wa_in_6(wa_in[6]), .wa_in_7(wa_in[7]),
        .wr_mask(wr_mask),
        .u0(uv[0]), .v0(uv[1]), .u1(uv[2]), .v1(uv[3]),
        .u2(uv[4]), .v2(uv[5]), .u3(uv[6]), .v3(uv[7]),
        .d0(d_b[0]), .d1(d_b[1]), .d2(d_b[2]), .d3(d_b[3]),
        .d4(d_b[4]), .d5(d_b[5]), .d6(d_b[6]), .d7(d_b[7]),
        .wa0(wa_b[0]), .wa1(wa_b[1]), .wa2(wa_b[2]), .wa3(wa_b[3]),
        .wa4(wa_b[4]), .wa5(wa_b[5]), .wa6(wa_b[6]), .wa7(wa_b[7]),
        .wen(wen_b), .busy(busy_b)
    );

    // Reference: one descriptor record per cycle plus the u/v values seen in that cycle.
    bit        hv  [N];
    bit [7:0]  hm  [N];
    bit [2:0]  hs  [N][8];
    bit [5:0]  hw  [N][8];
    bit [13:0] huv [N][8];

    // Values applied in the next cycle.
    bit        nv;
    bit        nrst;
    bit [7:0]  nm;
    bit [2:0]  nsel [8];
    bit [5:0]  nwa  [8];
    bit [13:0] nuv  [8];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int strobes;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Descriptor issued at c-lat writes now; its data comes from u/v seen at c-OUT.
    function automatic void model(input int lat, input int c,
                                  output logic [7:0] ew, output logic [111:0] ed,
                                  output logic [47:0] ea, output logic eb);
        int t;
        ew = '0; ed = '0; ea = '0; eb = 1'b0;
        for (int k = c - lat; k < c; k++)
            if (k >= 0 && hv[k]) eb = 1'b1;
        t = c - lat;
        if (t >= 0 && hv[t]) begin
            for (int i = 0; i < 8; i++) begin
                if (hm[t][i]) begin
                    ew[i]          = 1'b1;
                    ed[i*14 +: 14] = huv[c-OUT][hs[t][i]];
                    ea[i*6 +: 6]   = hw[t][i];
                end
            end
        end
    endfunction

    task automatic check_all();
        logic [7:0]   ew;
        logic [111:0] ed, oda, odb;
        logic [47:0]  ea, oaa, oab;
        logic         eb;
        for (int i = 0; i < 8; i++) begin
            oda[i*14 +: 14] = d_a[i];
            odb[i*14 +: 14] = d_b[i];
            oaa[i*6 +: 6]   = wa_a[i];
            oab[i*6 +: 6]   = wa_b[i];
        end
        model(LAT_A, cyc, ew, ed, ea, eb);
        chk("lat4_wen", {120'd0, wen_a}, {120'd0, ew});
        chk("lat4_d", {16'd0, oda}, {16'd0, ed});
        chk("lat4_wa", {80'd0, oaa}, {80'd0, ea});
        chk("lat4_busy", {127'd0, busy_a}, {127'd0, eb});
        if (wen_a != 8'h00) strobes++;
        model(LAT_B, cyc, ew, ed, ea, eb);
        chk("lat1_wen", {120'd0, wen_b}, {120'd0, ew});
        chk("lat1_d", {16'd0, odb}, {16'd0, ed});
        chk("lat1_wa", {80'd0, oab}, {80'd0, ea});
        chk("lat1_busy", {127'd0, busy_b}, {127'd0, eb});
    endtask

    // One cycle: apply inputs shortly after the rising edge, check mid-cycle.
    task automatic tick();
        rst      = nrst;
        in_valid = nv;
        wr_mask  = nm;
        for (int i = 0; i < 8; i++) begin
            sel_b[i] = nsel[i];
            wa_in[i] = nwa[i];
            uv[i]    = nuv[i];
            hs[cyc][i]  = nsel[i];
            hw[cyc][i]  = nwa[i];
            huv[cyc][i] = nuv[i];
        end
        hv[cyc] = nv & nrst;
        hm[cyc] = nm;
        if (!nrst)
            for (int k = 0; k <= cyc; k++) hv[k] = 1'b0;
        #3;
        check_all();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic idle(input int n);
        nv = 1'b0;
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic rand_desc();
        nm = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            nsel[i] = 3'($urandom);
            nwa[i]  = 6'($urandom);
        end
    endtask

    task automatic rand_uv();
        for (int i = 0; i < 8; i++) nuv[i] = 14'($urandom);
    endtask

    initial begin
        nv = 1'b0; nrst = 1'b0; nm = '0;
        for (int i = 0; i < 8; i++) begin
            nsel[i] = '0; nwa[i] = '0; nuv[i] = '0;
        end
        rst = 1'b0; in_valid = 1'b0; wr_mask = '0;
        for (int i = 0; i < 8; i++) begin
            sel_b[i] = '0; wa_in[i] = '0; uv[i] = '0;
        end
        @(posedge clk);
        #2;

        // Reset state, with inputs toggling underneath.
        rand_uv();
        rand_desc();
        nv = 1'b1;
        tick();
        tick();
        nrst = 1'b1;
        idle(2);

        // Identity routing.
        for (int i = 0; i < 8; i++) begin
            nsel[i] = 3'(i);
            nwa[i]  = 6'd5;
            nuv[i]  = 14'(i + 1);
        end
        nm = 8'hFF;
        nv = 1'b1;
        tick();
        idle(7);

        // Masking and broadcast of v1.
        rand_uv();
        nuv[3] = 14'h1234;
        for (int i = 0; i < 8; i++) begin
            nsel[i] = 3'd3;
            nwa[i]  = 6'(i + 20);
        end
        nm = 8'hA5;
        nv = 1'b1;
        tick();
        idle(7);

        // Ten back-to-back issues with distinct addresses.
        strobes = 0;
        for (int j = 0; j < 10; j++) begin
            rand_desc();
            nm = 8'($urandom) | 8'h01;
            for (int i = 0; i < 8; i++) nwa[i] = 6'(j + 40);
            rand_uv();
            nv = 1'b1;
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            rand_uv();
            idle(1);
        end
        chk("throughput_strobe_cycles", 128'(strobes), 128'd10);

        // Bubble pattern 1,0,1.
        rand_desc();
        nm = 8'hFF;
        nv = 1'b1; tick();
        nv = 1'b0; tick();
        rand_desc();
        nm = 8'h3C;
        nv = 1'b1; tick();
        for (int j = 0; j < 7; j++) begin
            rand_uv();
            idle(1);
        end

        // Reset while a descriptor is in flight.
        rand_desc();
        nm = 8'hFF;
        nv = 1'b1; tick();
        nv = 1'b0; tick();
        nrst = 1'b0; tick();
        nrst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            rand_uv();
            idle(1);
        end

        // Randomised traffic with occasional resets.
        for (int j = 0; j < 300; j++) begin
            rand_desc();
            rand_uv();
            nv   = ($urandom_range(0, 9) < 7);
            nrst = ($urandom_range(0, 49) != 0);
            tick();
        end
        nrst = 1'b1;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
